// File: rtl/au_incdec_arb.sv
// au_incdec_arb: round-robin bank of NCH counters sharing one external inc/dec unit; ports: clk, rst_n, req_vld/req_dec/req_rdy, ld_vld/ld_ch/ld_val, au_a/au_ci/au_inc_dec -> au_z/au_co, rsp_vld/rsp_ch/rsp_val/rsp_wrap, cnt_flat
module au_incdec_arb #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int SAT = 0,
  localparam int CHW = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req_vld,
  input  logic [NCH-1:0]     req_dec,
  output logic [NCH-1:0]     req_rdy,
  input  logic               ld_vld,
  input  logic [CHW-1:0]     ld_ch,
  input  logic [WIDTH-1:0]   ld_val,
  output logic [WIDTH-1:0]   au_a,
  output logic               au_ci,
  output logic               au_inc_dec,
  input  logic [WIDTH-1:0]   au_z,
  input  logic               au_co,
  output logic               rsp_vld,
  output logic [CHW-1:0]     rsp_ch,
  output logic [WIDTH-1:0]   rsp_val,
  output logic               rsp_wrap,
  output logic [NCH*WIDTH-1:0] cnt_flat
);
  logic [WIDTH-1:0] cnt [NCH];
  logic [CHW-1:0] p, g;
  logic [NCH-1:0] elig;
  logic hit, hold;
  always_comb begin
    elig = '0;
    g = '0;
    hit = 1'b0;
    req_rdy = '0;
    for (int i = 0; i < NCH; i++) elig[i] = req_vld[i] & ~(ld_vld & (int'(ld_ch) == i));
    for (int k = 0; k < NCH; k++)
      if (!hit && elig[(int'(p) + k) % NCH]) begin
        hit = 1'b1;
        g = CHW'((int'(p) + k) % NCH);
      end
    if (hit) req_rdy[g] = 1'b1;
  end
  assign au_a = hit ? cnt[g] : '0;
  assign au_ci = hit;
  assign au_inc_dec = hit & req_dec[g];
  // saturating build keeps the old value whenever the shared unit reports carry/borrow
  assign hold = (SAT != 0) && au_co;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '{default: '0};
      p <= '0;
      rsp_vld <= 1'b0;
      rsp_ch <= '0;
      rsp_val <= '0;
      rsp_wrap <= 1'b0;
    end else begin
      rsp_vld <= hit;
      if (hit) begin
        if (!hold) cnt[g] <= au_z;
        p <= (g == CHW'(NCH - 1)) ? '0 : g + 1'b1;
        rsp_ch <= g;
        rsp_val <= hold ? cnt[g] : au_z;
        rsp_wrap <= au_co;
      end
      if (ld_vld && int'(ld_ch) < NCH) cnt[ld_ch] <= ld_val;
    end
  for (genvar i = 0; i < NCH; i++) assign cnt_flat[i*WIDTH +: WIDTH] = cnt[i];
endmodule

// File: doc/au_incdec_arb.md
Name: au_incdec_arb

Overview:
- Counter-bank controller that time-shares one external AU_incdec_c instance among NCH requesters.
- Each channel owns a WIDTH-bit counter register.
- A round-robin arbiter grants at most one increment/decrement request per cycle. It drives the shared unit's a/ci/inc_dec from the granted counter and writes back z, returning a registered response with the carry/borrow flag.
- Used for credit counters, occupancy trackers and event tallies that do not justify one adder per channel.

Parameters:
- WIDTH, 8, counter word length (>= 1).
- NCH, 4, number of requesters/counters (>= 2).
- SAT, 0, 0: counters wrap on carry/borrow; 1: counters saturate (hold at all-ones / zero).
- CHW (local), clog2(NCH), channel index width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_vld  input  NCH  per-channel request valid.
- req_dec  input  NCH  per-channel op: 0 increment, 1 decrement.
- req_rdy  output  NCH  one-hot grant; a request completes in a cycle where req_vld[i]&req_rdy[i].
- ld_vld  input  1  load strobe.
- ld_ch  input  CHW  channel to load.
- ld_val  input  WIDTH  load value.
- au_a  output  WIDTH  to shared unit operand a.
- au_ci  output  1  to shared unit ci.
- au_inc_dec  output  1  to shared unit inc_dec.
- au_z  input  WIDTH  from shared unit z (combinational return).
- au_co  input  1  from shared unit co.
- rsp_vld  output  1  response valid, one cycle per completed request.
- rsp_ch  output  CHW  channel of response.
- rsp_val  output  WIDTH  counter value after update.
- rsp_wrap  output  1  carry-out (inc) or borrow (dec) occurred.
- cnt_flat  output  NCH*WIDTH  all counters, channel i at [i*WIDTH +: WIDTH].

Behaviour:
- Reset (async, rst_n=0): all counters 0, rr pointer 0, rsp_vld/rsp_ch/rsp_val/rsp_wrap 0. req_rdy and au_* are combinational and therefore 0 with no requests.
- Eligibility: elig[i] = req_vld[i] & ~(ld_vld & ld_ch==i). Channels with ld_ch >= NCH are ignored for both masking and loading.
- Arbitration: combinational round-robin over elig, starting search at pointer p. Winner g gets req_rdy[g]=1; all other req_rdy bits 0. No eligible request: req_rdy=0.
- Datapath drive when granted: au_a=cnt[g], au_ci=1, au_inc_dec=req_dec[g].
- Datapath drive when idle: au_a=0, au_ci=0, au_inc_dec=0.
- Counter update on grant, at the clock edge:
  - SAT=0 or au_co=0: cnt[g] <= au_z.
  - SAT=1 and au_co=1: cnt[g] holds (value stays at 2^WIDTH-1 for inc, 0 for dec).
  - Pointer p <= (g+1) mod NCH.
  - No grant: p holds.
- Response: registered, latency 1. Cycle after a grant: rsp_vld=1, rsp_ch=g, rsp_val=new cnt[g], rsp_wrap=au_co sampled at grant. Otherwise rsp_vld=0 and other rsp fields hold. No back-pressure on responses.
- Load: ld_vld=1 writes cnt[ld_ch] <= ld_val at the edge and produces no response. Load and a grant to a different channel in the same cycle both take effect.
- Throughput: one update per cycle. Back-to-back grants to the same channel (only requester) use the updated value each cycle.
- cnt_flat is a direct register view, updated the edge after a grant/load.
- Reset mid-operation: any in-flight response is dropped; state returns to reset values immediately.
- WIDTH=1 must work: inc of 1 gives 0 with wrap=1 (SAT=0).

Test Plan:
- Reset then idle: rsp_vld=0, cnt_flat=0, au_ci=0, req_rdy=0 for 10 cycles.
- NCH=4, WIDTH=8, SAT=0: req_vld=4'b1111, all inc, held 8 cycles -> grants 0,1,2,3,0,1,2,3. Each counter ends at 2. Responses follow one cycle later in the same order.
- Wrap: load ch2=8'hFF, single inc -> rsp_val=8'h00, rsp_wrap=1. Load ch1=0, dec -> rsp_val=8'hFF, rsp_wrap=1.
- SAT=1: ch0=8'hFF inc -> rsp_val=8'hFF, rsp_wrap=1, cnt unchanged. ch3=0 dec -> stays 0, rsp_wrap=1.
- Load collision: req_vld=4'b0011, ld_vld=1, ld_ch=0, ld_val=8'h55 -> req_rdy=4'b0010, ch1 updated, cnt[0]=8'h55, no response for ch0.
- Async reset asserted mid-burst between edges -> outputs and counters zero immediately. After release, the first grant goes to the lowest requesting channel from pointer 0.
